// File: rtl/s298_resp_misr.sv
// rtl/s298_resp_misr.sv - 16-bit response MISR compactor for the s298 BIST harness
module s298_resp_misr #(
  parameter int                WIDTH  = 16,
  parameter logic [WIDTH-1:0]  POLY   = 16'h1021,
  parameter logic [WIDTH-1:0]  SEED   = 16'hFFFF,
  parameter int                WARMUP = 4,
  parameter int                NPAT   = 256,
  parameter logic [WIDTH-1:0]  GOLDEN = 16'h0000
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             START,
  input  logic [5:0]       RESP,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [WIDTH-1:0] SIG,
  output logic [15:0]      CNT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WARM,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [15:0] WARM_LAST = 16'(WARMUP - 1);
  localparam logic [15:0] NPAT_LAST = 16'(NPAT - 1);

  state_t           state;
  state_t           state_nx;
  logic [15:0]      wcnt;
  logic [WIDTH-1:0] sig_step;

  // Galois shift with feedback on the outgoing MSB, then fold in the response
  always_comb begin
    sig_step = {SIG[WIDTH-2:0], 1'b0} ^ (SIG[WIDTH-1] ? POLY : '0) ^ WIDTH'(RESP);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (START) state_nx = (WARMUP > 0) ? S_WARM : S_RUN;
      end
      S_WARM: begin
        if (wcnt == WARM_LAST) state_nx = S_RUN;
      end
      S_RUN: begin
        if (CNT == NPAT_LAST) state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // BUSY/DONE are decoded from the next state so every output is a flop
  always_ff @(posedge CK) begin
    if (RST) begin
      state <= S_IDLE;
      SIG   <= SEED;
      CNT   <= '0;
      wcnt  <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      PASS  <= 1'b0;
    end else begin
      state <= state_nx;
      BUSY  <= (state_nx == S_WARM) || (state_nx == S_RUN);
      DONE  <= (state_nx == S_DONE);
      case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            SIG  <= SEED;
            CNT  <= '0;
            PASS <= 1'b0;
            wcnt <= '0;
          end
        end
        S_WARM: begin
          wcnt <= wcnt + 16'd1;
        end
        S_RUN: begin
          SIG <= sig_step;
          if (CNT != 16'hFFFF) CNT <= CNT + 16'd1;
          if (state_nx == S_DONE) PASS <= (sig_step == GOLDEN);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_s298_resp_misr.sv
// tb/tb_s298_resp_misr.sv - self-checking bench for s298_resp_misr
module tb_s298_resp_misr;

  logic        CK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [5:0]  RESP = '0;
  logic [4:0]  busy;
  logic [4:0]  done;
  logic [4:0]  pass;
  logic [15:0] sig [5];
  logic [15:0] cnt [5];

  int passed = 0;
  int total  = 0;

  always #5 CK = ~CK;

  // d0 default, d1..d3 short runs without warm-up, d4 zero-seed full-length run
  s298_resp_misr d0 (.CK(CK), .RST(RST), .START(START), .RESP(RESP),
    .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]), .SIG(sig[0]), .CNT(cnt[0]));
  s298_resp_misr #(.SEED(16'h0000), .WARMUP(0), .NPAT(1), .GOLDEN(16'h0000)) d1 (
    .CK(CK), .RST(RST), .START(START), .RESP(RESP),
    .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]), .SIG(sig[1]), .CNT(cnt[1]));
  s298_resp_misr #(.SEED(16'h0000), .WARMUP(0), .NPAT(2), .GOLDEN(16'h0000)) d2 (
    .CK(CK), .RST(RST), .START(START), .RESP(RESP),
    .BUSY(busy[2]), .DONE(done[2]), .PASS(pass[2]), .SIG(sig[2]), .CNT(cnt[2]));
  s298_resp_misr #(.SEED(16'h8000), .WARMUP(0), .NPAT(1), .GOLDEN(16'h1021)) d3 (
    .CK(CK), .RST(RST), .START(START), .RESP(RESP),
    .BUSY(busy[3]), .DONE(done[3]), .PASS(pass[3]), .SIG(sig[3]), .CNT(cnt[3]));
  s298_resp_misr #(.SEED(16'h0000), .WARMUP(4), .NPAT(256), .GOLDEN(16'h0000)) d4 (
    .CK(CK), .RST(RST), .START(START), .RESP(RESP),
    .BUSY(busy[4]), .DONE(done[4]), .PASS(pass[4]), .SIG(sig[4]), .CNT(cnt[4]));

  typedef struct {
    logic [5:0]  r0;
    logic [5:0]  r1;
    logic [15:0] e1;
    logic [15:0] e2;
    logic [15:0] e3;
    logic        p2;
  } vec_t;

  vec_t tbl [5];
  int   resp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // Signature as polynomial arithmetic over the recorded responses
  function automatic int fold(input int seed, input int n);
    int s = seed;
    for (int i = 0; i < n; i++) begin
      int msb = (s >= 32768) ? 1 : 0;
      s = (s * 2) % 65536;
      if (msb == 1) s = s ^ 'h1021;
      s = s ^ resp_q[i];
    end
    return s;
  endfunction

  initial begin
    int k;
    int n;
    int found;
    int prev_busy;
    int e;

    tbl[0] = '{6'h01, 6'h01, 16'h0001, 16'h0003, 16'h1020, 1'b0};
    tbl[1] = '{6'h00, 6'h00, 16'h0000, 16'h0000, 16'h1021, 1'b1};
    tbl[2] = '{6'h3F, 6'h00, 16'h003F, 16'h007E, 16'h101E, 1'b0};
    tbl[3] = '{6'h2A, 6'h15, 16'h002A, 16'h0041, 16'h100B, 1'b0};
    tbl[4] = '{6'h01, 6'h02, 16'h0001, 16'h0000, 16'h1020, 1'b1};

    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    chk("rst_sig0", 32'(sig[0]), 32'h0000_FFFF);
    chk("rst_sig3", 32'(sig[3]), 32'h0000_8000);
    chk("rst_cnt0", 32'(cnt[0]), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_pass", 32'(pass), 32'h0);

    // Short-run table; each row after the first also restarts from DONE
    for (int i = 0; i < 5; i++) begin
      START = 1'b1;
      tick();
      START = 1'b0;
      chk("tbl_reload_sig2", 32'(sig[2]), 32'h0);
      chk("tbl_reload_busy2", 32'(busy[2]), 32'h1);
      RESP = tbl[i].r0;
      tick();
      chk("tbl_d1_sig", 32'(sig[1]), 32'(tbl[i].e1));
      chk("tbl_d1_done", 32'(done[1]), 32'h1);
      chk("tbl_d1_cnt", 32'(cnt[1]), 32'h1);
      chk("tbl_d1_pass", 32'(pass[1]), (tbl[i].e1 == 16'h0) ? 32'h1 : 32'h0);
      chk("tbl_d2_midbusy", 32'(busy[2]), 32'h1);
      chk("tbl_d2_middone", 32'(done[2]), 32'h0);
      RESP = tbl[i].r1;
      tick();
      chk("tbl_d2_sig", 32'(sig[2]), 32'(tbl[i].e2));
      chk("tbl_d2_done", 32'(done[2]), 32'h1);
      chk("tbl_d2_pass", 32'(pass[2]), 32'(tbl[i].p2));
      chk("tbl_d2_cnt", 32'(cnt[2]), 32'h2);
      chk("tbl_d3_sig", 32'(sig[3]), 32'(tbl[i].e3));
      chk("tbl_d3_pass", 32'(pass[3]), (tbl[i].e3 == 16'h1021) ? 32'h1 : 32'h0);
      chk("tbl_d1_hold", 32'(sig[1]), 32'(tbl[i].e1));
    end

    // Randomized full run on the default instance with a stray mid-run START
    RST = 1'b1;
    tick();
    RST = 1'b0;
    START = 1'b1;
    RESP = 6'($urandom);
    tick();
    START = 1'b0;
    resp_q.delete();
    for (k = 1; k <= 262; k++) begin
      RESP = 6'($urandom);
      START = (k == 100 || k == 3) ? 1'b1 : 1'b0;
      if (k > 4 && k <= 260) resp_q.push_back(int'(RESP));
      tick();
      START = 1'b0;
      n = resp_q.size();
      chk("rnd_sig", 32'(sig[0]), 32'(fold('hFFFF, n)));
      chk("rnd_cnt", 32'(cnt[0]), 32'(n));
      chk("rnd_busy", 32'(busy[0]), (k < 260) ? 32'h1 : 32'h0);
      chk("rnd_done", 32'(done[0]), (k >= 260) ? 32'h1 : 32'h0);
    end
    chk("rnd_pass", 32'(pass[0]), (fold('hFFFF, 256) == 0) ? 32'h1 : 32'h0);

    START = 1'b1;
    tick();
    START = 1'b0;
    chk("restart_sig", 32'(sig[0]), 32'h0000_FFFF);
    chk("restart_cnt", 32'(cnt[0]), 32'h0);
    chk("restart_busy", 32'(busy[0]), 32'h1);
    chk("restart_done", 32'(done[0]), 32'h0);
    chk("restart_pass", 32'(pass[0]), 32'h0);

    // Abort by reset at CNT=10, with START on the same edge
    found = 0;
    for (int j = 0; j < 50 && found == 0; j++) begin
      if (cnt[0] == 16'd10) found = 1;
      else tick();
    end
    chk("cnt10_reached", 32'(found), 32'h1);
    RST = 1'b1;
    START = 1'b1;
    tick();
    RST = 1'b0;
    START = 1'b0;
    chk("abort_sig", 32'(sig[0]), 32'h0000_FFFF);
    chk("abort_cnt", 32'(cnt[0]), 32'h0);
    chk("abort_busy", 32'(busy[0]), 32'h0);
    chk("abort_done", 32'(done[0]), 32'h0);
    chk("abort_pass", 32'(pass[0]), 32'h0);
    tick();
    chk("abort_idle", 32'(busy[0]), 32'h0);

    // Zero-seed, zero-response 256-pattern run: DONE latency and BUSY handoff
    RESP = 6'h00;
    START = 1'b1;
    tick();
    START = 1'b0;
    e = 0;
    prev_busy = 0;
    for (k = 1; k <= 300 && e == 0; k++) begin
      prev_busy = int'(busy[4]);
      tick();
      if (done[4]) e = k;
    end
    chk("lat_done_edge", 32'(e), 32'd260);
    chk("lat_prev_busy", 32'(prev_busy), 32'h1);
    chk("lat_busy_fell", 32'(busy[4]), 32'h0);
    chk("lat_sig", 32'(sig[4]), 32'h0);
    chk("lat_pass", 32'(pass[4]), 32'h1);
    chk("lat_cnt", 32'(cnt[4]), 32'd256);
    tick();
    chk("lat_hold_done", 32'(done[4]), 32'h1);
    chk("lat_hold_cnt", 32'(cnt[4]), 32'd256);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
